jace_ps2_keyboard: RTL and testbench

PS/2 keyboard front end for the Jupiter Ace core. It receives PS/2 set-2 scancodes and maintains an 8-row × 5-column Ace key matrix. The matrix is presented on the `kbdcols` input of the logic block. The CPU selects rows through address lines A15–A8 during the port-FE read, exactly as on the original machine.

---
 rtl/jace_ps2_keyboard.sv | 210 +++++++++++++++++++++
 tb/tb_jace_ps2_keyboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jace_ps2_keyboard.sv
// PS/2 set-2 keyboard front end for the Jupiter Ace: receives scancodes and
// maintains the 8x5 key matrix read by the CPU through address lines A15-A8.
module jace_ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 6500,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] rows,
    output logic [4:0] kbdcols,
    output logic [7:0] code,
    output logic       code_valid
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    rx_state_t       state, next_state;
    logic            ps2clk_s1, ps2clk_s2, ps2data_s1, ps2data_s2;
    logic            filt, filt_d, tick;
    logic [FW-1:0]   filt_cnt;
    logic [TW-1:0]   to_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            byte_ok, frame_bad;
    logic            rel_flag, ext_flag, bksp;
    logic [7:0][4:0] matrix;
    logic [7:0][4:0] eff_matrix;
    logic [6:0]      key_sel;

    // Returns {hit, row, col} for a scancode; Backspace is handled separately.
    function automatic logic [6:0] key_map(input logic ext, input logic [7:0] b);
        key_map = 7'd0;
        if (ext) begin
            case (b)
                8'h14:        key_map = {1'b1, 3'd0, 3'd1};
                8'h5A:        key_map = {1'b1, 3'd6, 3'd0};
                default:      key_map = 7'd0;
            endcase
        end else begin
            case (b)
                8'h12, 8'h59: key_map = {1'b1, 3'd0, 3'd0};
                8'h14:        key_map = {1'b1, 3'd0, 3'd1};
                8'h1A:        key_map = {1'b1, 3'd0, 3'd2};
                8'h22:        key_map = {1'b1, 3'd0, 3'd3};
                8'h21:        key_map = {1'b1, 3'd0, 3'd4};
                8'h1C:        key_map = {1'b1, 3'd1, 3'd0};
                8'h1B:        key_map = {1'b1, 3'd1, 3'd1};
                8'h23:        key_map = {1'b1, 3'd1, 3'd2};
                8'h2B:        key_map = {1'b1, 3'd1, 3'd3};
                8'h34:        key_map = {1'b1, 3'd1, 3'd4};
                8'h15:        key_map = {1'b1, 3'd2, 3'd0};
                8'h1D:        key_map = {1'b1, 3'd2, 3'd1};
                8'h24:        key_map = {1'b1, 3'd2, 3'd2};
                8'h2D:        key_map = {1'b1, 3'd2, 3'd3};
                8'h2C:        key_map = {1'b1, 3'd2, 3'd4};
                8'h16:        key_map = {1'b1, 3'd3, 3'd0};
                8'h1E:        key_map = {1'b1, 3'd3, 3'd1};
                8'h26:        key_map = {1'b1, 3'd3, 3'd2};
                8'h25:        key_map = {1'b1, 3'd3, 3'd3};
                8'h2E:        key_map = {1'b1, 3'd3, 3'd4};
                8'h45:        key_map = {1'b1, 3'd4, 3'd0};
                8'h46:        key_map = {1'b1, 3'd4, 3'd1};
                8'h3E:        key_map = {1'b1, 3'd4, 3'd2};
                8'h3D:        key_map = {1'b1, 3'd4, 3'd3};
                8'h36:        key_map = {1'b1, 3'd4, 3'd4};
                8'h4D:        key_map = {1'b1, 3'd5, 3'd0};
                8'h44:        key_map = {1'b1, 3'd5, 3'd1};
                8'h43:        key_map = {1'b1, 3'd5, 3'd2};
                8'h3C:        key_map = {1'b1, 3'd5, 3'd3};
                8'h35:        key_map = {1'b1, 3'd5, 3'd4};
                8'h5A:        key_map = {1'b1, 3'd6, 3'd0};
                8'h4B:        key_map = {1'b1, 3'd6, 3'd1};
                8'h42:        key_map = {1'b1, 3'd6, 3'd2};
                8'h3B:        key_map = {1'b1, 3'd6, 3'd3};
                8'h33:        key_map = {1'b1, 3'd6, 3'd4};
                8'h29:        key_map = {1'b1, 3'd7, 3'd0};
                8'h3A:        key_map = {1'b1, 3'd7, 3'd1};
                8'h31:        key_map = {1'b1, 3'd7, 3'd2};
                8'h32:        key_map = {1'b1, 3'd7, 3'd3};
                8'h2A:        key_map = {1'b1, 3'd7, 3'd4};
                default:      key_map = 7'd0;
            endcase
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps2clk_s1  <= 1'b1;
            ps2clk_s2  <= 1'b1;
            ps2data_s1 <= 1'b1;
            ps2data_s2 <= 1'b1;
            filt       <= 1'b1;
            filt_d     <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            ps2clk_s1  <= ps2clk;
            ps2clk_s2  <= ps2clk_s1;
            ps2data_s1 <= ps2data;
            ps2data_s2 <= ps2data_s1;
            filt_d     <= filt;
            if (ps2clk_s2 == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= ps2clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign tick = filt_d & ~filt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE || tick) to_cnt <= '0;
            else                       to_cnt <= to_cnt + TW'(1);
            if (tick) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {ps2data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= ps2data_s2;
                    default: ;
                endcase
            end
        end
    end

    // A timeout takes priority only when no tick arrives in the same cycle.
    always_comb begin
        next_state = state;
        byte_ok    = 1'b0;
        frame_bad  = 1'b0;
        if (state != IDLE && !tick && to_cnt == TW'(TIMEOUT_CYCLES)) begin
            next_state = IDLE;
        end else if (tick) begin
            case (state)
                IDLE:   if (!ps2data_s2) next_state = DATA;
                DATA:   if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY: next_state = STOP;
                STOP: begin
                    next_state = IDLE;
                    if (ps2data_s2 && ^{shreg, par_bit}) byte_ok = 1'b1;
                    else                                 frame_bad = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign key_sel = key_map(ext_flag, shreg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            rel_flag   <= 1'b0;
            ext_flag   <= 1'b0;
            bksp       <= 1'b0;
            matrix     <= '1;
        end else begin
            code_valid <= 1'b0;
            if (byte_ok) begin
                code       <= shreg;
                code_valid <= 1'b1;
                if (shreg == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else begin
                    if (!ext_flag && shreg == 8'h66) bksp <= ~rel_flag;
                    else if (key_sel[6])             matrix[key_sel[5:3]][key_sel[2:0]] <= rel_flag;
                    rel_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end
            end else if (frame_bad) begin
                rel_flag <= 1'b0;
                ext_flag <= 1'b0;
            end
        end
    end

    // Backspace presents as SHIFT+0 without touching the physical key bits.
    always_comb begin
        eff_matrix       = matrix;
        eff_matrix[0][0] = matrix[0][0] & ~bksp;
        eff_matrix[4][0] = matrix[4][0] & ~bksp;
        kbdcols          = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!rows[r]) kbdcols = kbdcols & eff_matrix[r];
        end
    end

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Directed bench for jace_ps2_keyboard: drives PS/2 frames bit by bit and
// checks code, code_valid pulses and the row/column matrix readout.
module tb_jace_ps2_keyboard;

    localparam int TIMEOUT_CYCLES = 6500;

    logic       clk;
    logic       rst_n;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] rows;
    logic [4:0] kbdcols;
    logic [7:0] code;
    logic       code_valid;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;

    jace_ps2_keyboard #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FILTER_LEN(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2clk(ps2clk),
        .ps2data(ps2data),
        .rows(rows),
        .kbdcols(kbdcols),
        .code(code),
        .code_valid(code_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (code_valid) pulses <= pulses + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2data = b;
        repeat (20) @(negedge clk);
        ps2clk = 1'b0;
        repeat (40) @(negedge clk);
        ps2clk = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Sends one full frame; bad_par flips the parity bit.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic read_cols(input logic [7:0] sel, output int cols);
        rows = sel;
        #1;
        cols = int'(kbdcols);
    endtask

    int c;

    initial begin
        rst_n   = 1'b0;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        rows    = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        read_cols(8'h00, c);
        checkOutput("reset_cols", c, 5'b11111);
        checkOutput("reset_code", int'(code), 8'h00);
        repeat (200) @(negedge clk);
        checkOutput("idle_pulses", pulses, 0);

        p0 = pulses;
        applyStimulus(8'h1C, 1'b0);
        checkOutput("a_pulse", pulses - p0, 1);
        checkOutput("a_code", int'(code), 8'h1C);
        read_cols(8'hFD, c);
        checkOutput("a_press", c, 5'b11110);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h1C, 1'b0);
        read_cols(8'hFD, c);
        checkOutput("a_release", c, 5'b11111);

        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        read_cols(8'hBF, c);
        checkOutput("kp_enter", c, 5'b11110);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        read_cols(8'hBF, c);
        checkOutput("kp_enter_rel", c, 5'b11111);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h71, 1'b0);
        read_cols(8'h00, c);
        checkOutput("e0_71_ignored", c, 5'b11111);

        applyStimulus(8'h66, 1'b0);
        read_cols(8'hEE, c);
        checkOutput("bksp_both", c, 5'b11110);
        read_cols(8'hEF, c);
        checkOutput("bksp_zero", c, 5'b11110);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h12, 1'b0);
        read_cols(8'hFE, c);
        checkOutput("bksp_shift_held", c, 5'b11110);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h66, 1'b0);
        read_cols(8'hEE, c);
        checkOutput("bksp_release", c, 5'b11111);

        p0 = pulses;
        applyStimulus(8'h1C, 1'b1);
        checkOutput("par_err_pulse", pulses - p0, 0);
        read_cols(8'hFD, c);
        checkOutput("par_err_matrix", c, 5'b11111);
        applyStimulus(8'h1B, 1'b0);
        checkOutput("s_code", int'(code), 8'h1B);
        read_cols(8'hFD, c);
        checkOutput("s_press", c, 5'b11101);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h1B, 1'b0);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
        p0 = pulses;
        applyStimulus(8'h1D, 1'b0);
        checkOutput("timeout_pulse", pulses - p0, 1);
        checkOutput("timeout_code", int'(code), 8'h1D);

        p0 = pulses;
        ps2data = 1'b0;
        ps2clk  = 1'b0;
        repeat (2) @(negedge clk);
        ps2clk  = 1'b1;
        repeat (30) @(negedge clk);
        ps2data = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(8'h24, 1'b0);
        checkOutput("glitch_pulse", pulses - p0, 1);
        checkOutput("glitch_code", int'(code), 8'h24);
        read_cols(8'hFB, c);
        checkOutput("w_e_held", c, 5'b11001);

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        read_cols(8'h00, c);
        checkOutput("midreset_cols", c, 5'b11111);
        checkOutput("midreset_code", int'(code), 8'h00);
        applyStimulus(8'h2D, 1'b0);
        checkOutput("after_reset_code", int'(code), 8'h2D);
        read_cols(8'hFB, c);
        checkOutput("r_press", c, 5'b10111);
        read_cols(8'hFF, c);
        checkOutput("no_row", c, 5'b11111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
